// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the returned word into the IF/ID register, applying decode redirects and stalls.
module fetch_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic                  jump,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic                  id_valid
);

    logic                  take_jump;
    logic                  take_branch;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] next_redirect;

    // Redirects only mean something while the IF/ID slot holds a live instruction.
    assign take_jump   = jump & id_valid;
    assign take_branch = branch_taken & id_valid & ~jump;

    // Word offset, sign-extended then reduced modulo the PC width.
    assign offset        = ADDR_WIDTH'(signed'(id_instr[15:0]));
    assign jump_target   = id_instr[ADDR_WIDTH-1:0];
    assign branch_target = id_pc + ADDR_WIDTH'(1) + offset;
    assign next_redirect = take_jump ? jump_target : branch_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= ADDR_WIDTH'(RESET_PC);
            id_instr <= '0;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (take_jump || take_branch) begin
            // Redirect beats stall: the redirecting instruction has finished decode.
            addr     <= next_redirect;
            id_instr <= instruction;
            id_pc    <= addr;
            id_valid <= 1'b0;
        end else if (!stall) begin
            addr     <= addr + ADDR_WIDTH'(1);
            id_instr <= instruction;
            id_pc    <= addr;
            id_valid <= 1'b1;
        end
    end

endmodule
